// File: rtl/arp_tx.sv
// ARP transmit framer: builds an Ethernet II ARP request/reply and streams it over GMII.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff,
  parameter logic [31:0] DES_IP    = {8'd192, 8'd168, 8'd1, 8'd102}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    ARP_DATA,
    FCS,
    IFG
  } state_t;

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic               r_type;
  logic [47:0]        r_mac;
  logic [31:0]        r_ip;
  logic [31:0]        r_crc;
  logic               r_tx_en;
  logic [7:0]         r_txd;
  logic               r_busy;
  logic               r_done;

  logic [0:13][7:0]   w_head;
  logic [0:45][7:0]   w_arp;
  logic [47:0]        w_dst;
  logic [47:0]        w_tmac;
  logic [15:0]        w_op;
  logic [7:0]         w_byte;
  logic [7:0]         w_d;
  logic [31:0]        w_crc_next;
  logic [31:0]        w_rev;
  logic [3:0][7:0]    w_fcs;

  always_comb begin
    w_dst  = r_type ? r_mac : '1;
    w_tmac = r_type ? r_mac : '0;
    w_op   = r_type ? 16'h0002 : 16'h0001;
    w_head = {w_dst, BOARD_MAC, 16'h0806};
    w_arp  = {48'h0001_0800_0604, w_op, BOARD_MAC, BOARD_IP, w_tmac, r_ip, 144'h0};
    w_byte = '0;
    case (r_state)
      ETH_HEAD: w_byte = w_head[r_cnt[3:0]];
      ARP_DATA: w_byte = w_arp[r_cnt];
      default:  w_byte = '0;
    endcase
  end

  // MSB-first register fed LSB-first data bits; the FCS is its reversed complement.
  always_comb begin
    w_crc_next = r_crc;
    w_d        = w_byte;
    for (int unsigned i = 0; i < 8; i++) begin
      w_crc_next = {w_crc_next[30:0], 1'b0} ^ ({32{w_crc_next[31] ^ w_d[0]}} & 32'h04C1_1DB7);
      w_d        = {1'b0, w_d[7:1]};
    end
    w_rev = {<<{r_crc}};
    w_fcs = ~w_rev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_type  <= 1'b0;
      r_mac   <= '0;
      r_ip    <= '0;
      r_crc   <= '1;
      r_tx_en <= 1'b0;
      r_txd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_en <= 1'b0;
          r_txd   <= '0;
          r_crc   <= '1;
          r_cnt   <= '0;
          if (arp_tx_en) begin
            r_type  <= arp_tx_type;
            r_mac   <= (des_mac == '0) ? DES_MAC : des_mac;
            r_ip    <= (des_ip == '0) ? DES_IP : des_ip;
            r_busy  <= 1'b1;
            r_state <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_txd   <= (r_cnt == 6'd7) ? 8'hD5 : 8'h55;
          if (r_cnt == 6'd7) begin
            r_cnt   <= '0;
            r_state <= ETH_HEAD;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ETH_HEAD: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_byte;
          r_crc   <= w_crc_next;
          if (r_cnt == 6'd13) begin
            r_cnt   <= '0;
            r_state <= ARP_DATA;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ARP_DATA: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_byte;
          r_crc   <= w_crc_next;
          if (r_cnt == 6'd45) begin
            r_cnt   <= '0;
            r_state <= FCS;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        FCS: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_fcs[r_cnt[1:0]];
          if (r_cnt == 6'd3) begin
            r_cnt   <= '0;
            r_state <= IFG;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        IFG: begin
          r_tx_en <= 1'b0;
          r_txd   <= '0;
          r_done  <= (r_cnt == 6'd0);
          if (r_cnt == 6'd11) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign gmii_tx_en = r_tx_en;
  assign gmii_txd   = r_txd;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_arp_tx.sv
module tb_arp_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arp_tx_en = 1'b0;
  logic        arp_tx_type = 1'b0;
  logic [47:0] des_mac = '0;
  logic [31:0] des_ip = '0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_busy;
  logic        tx_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] cap [0:99];
  logic [7:0] exp_f [0:71];
  int cap_len, done_cnt, done_at, trail_idle, trail_busy_low, wait_n, wait_busy_low;
  bit cap_to;
  int inj_at = -1;
  int rel_at = -1;
  logic [31:0] inj_ip = '0;

  arp_tx #(
    .BOARD_MAC(48'h00_11_22_33_44_55),
    .BOARD_IP ({8'd192, 8'd168, 8'd1, 8'd10}),
    .DES_MAC  (48'hff_ff_ff_ff_ff_ff),
    .DES_IP   ({8'd192, 8'd168, 8'd1, 8'd102})
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arp_tx_en  (arp_tx_en),
    .arp_tx_type(arp_tx_type),
    .des_mac    (des_mac),
    .des_ip     (des_ip),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #4 clk = ~clk;

  task automatic build_exp(input logic t, input logic [47:0] m, input logic [31:0] ip);
    logic [47:0] bm;
    logic [31:0] bi;
    logic [47:0] mm;
    logic [31:0] ii;
    logic [31:0] c;
    int p;
    bm = 48'h00_11_22_33_44_55;
    bi = 32'hC0_A8_01_0A;
    mm = (m == '0) ? 48'hFF_FF_FF_FF_FF_FF : m;
    ii = (ip == '0) ? 32'hC0_A8_01_66 : ip;
    for (int k = 0; k < 7; k++) exp_f[k] = 8'h55;
    exp_f[7] = 8'hD5;
    p = 8;
    for (int k = 5; k >= 0; k--) begin exp_f[p] = t ? mm[8*k +: 8] : 8'hFF; p++; end
    for (int k = 5; k >= 0; k--) begin exp_f[p] = bm[8*k +: 8]; p++; end
    exp_f[p] = 8'h08; exp_f[p+1] = 8'h06; p += 2;
    exp_f[p] = 8'h00; exp_f[p+1] = 8'h01; exp_f[p+2] = 8'h08;
    exp_f[p+3] = 8'h00; exp_f[p+4] = 8'h06; exp_f[p+5] = 8'h04; p += 6;
    exp_f[p] = 8'h00; exp_f[p+1] = t ? 8'h02 : 8'h01; p += 2;
    for (int k = 5; k >= 0; k--) begin exp_f[p] = bm[8*k +: 8]; p++; end
    for (int k = 3; k >= 0; k--) begin exp_f[p] = bi[8*k +: 8]; p++; end
    for (int k = 5; k >= 0; k--) begin exp_f[p] = t ? mm[8*k +: 8] : 8'h00; p++; end
    for (int k = 3; k >= 0; k--) begin exp_f[p] = ii[8*k +: 8]; p++; end
    for (int k = 0; k < 18; k++) begin exp_f[p] = 8'h00; p++; end
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < 68; k++) begin
      c ^= {24'h0, exp_f[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    exp_f[68] = c[7:0];
    exp_f[69] = c[15:8];
    exp_f[70] = c[23:16];
    exp_f[71] = c[31:24];
  endtask

  function automatic logic [31:0] residue();
    logic [31:0] c;
    logic [31:0] r;
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < 72; k++) begin
      c ^= {24'h0, cap[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return r;
  endfunction

  function automatic int bad_bytes();
    int n;
    n = 0;
    for (int k = 0; k < 72; k++) if (cap[k] !== exp_f[k]) n++;
    return n;
  endfunction

  task automatic capture();
    int w;
    cap_len = 0; cap_to = 0; done_cnt = 0; done_at = -1;
    trail_idle = 0; trail_busy_low = 0; wait_busy_low = 0;
    for (int k = 0; k < 100; k++) cap[k] = 'x;
    w = 0;
    while (gmii_tx_en !== 1'b1 && w < 300) begin
      if (tx_busy === 1'b0) wait_busy_low++;
      @(negedge clk);
      w++;
    end
    wait_n = w;
    if (gmii_tx_en !== 1'b1) begin
      cap_to = 1;
      return;
    end
    while (gmii_tx_en === 1'b1 && cap_len < 100) begin
      if (tx_done === 1'b1) done_cnt++;
      cap[cap_len] = gmii_txd;
      cap_len++;
      if (cap_len == inj_at) begin arp_tx_en = 1'b1; des_ip = inj_ip; end
      if (cap_len == rel_at) arp_tx_en = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 12; k++) begin
      if (tx_done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (gmii_tx_en === 1'b0 && gmii_txd === 8'h00) trail_idle++;
      if (tx_busy === 1'b0) trail_busy_low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (gmii_tx_en !== 1'b0) begin fails++; $display("FAIL rst_tx_en: got %b want 0", gmii_tx_en); end
    tests++; if (gmii_txd !== 8'h00) begin fails++; $display("FAIL rst_txd: got %h want 00", gmii_txd); end
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", tx_done); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++; if (gmii_tx_en !== 1'b0 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL idle_after_rst: tx_en %b busy %b want 0 0", gmii_tx_en, tx_busy);
    end
  endtask

  task automatic test_request();
    int nb;
    arp_tx_type = 1'b0; des_mac = '0; des_ip = '0;
    build_exp(1'b0, 48'h0, 32'h0);
    arp_tx_en = 1'b1;
    @(negedge clk);
    tests++; if (tx_busy !== 1'b1 || gmii_tx_en !== 1'b0) begin
      fails++; $display("FAIL req_latency1: busy %b tx_en %b want 1 0", tx_busy, gmii_tx_en);
    end
    arp_tx_en = 1'b0;
    @(negedge clk);
    tests++; if (gmii_tx_en !== 1'b1 || gmii_txd !== 8'h55) begin
      fails++; $display("FAIL req_latency2: tx_en %b txd %h want 1 55", gmii_tx_en, gmii_txd);
    end
    capture();
    tests++; if (cap_to || cap_len != 72) begin fails++; $display("FAIL req_len: got %0d (timeout %0d) want 72", cap_len, cap_to); end
    nb = bad_bytes();
    tests++; if (nb != 0) begin fails++; $display("FAIL req_bytes: %0d bytes differ, want 0", nb); end
    tests++; if (cap[8] !== 8'hFF || cap[49] !== 8'h66 || cap[29] !== 8'h01) begin
      fails++; $display("FAIL req_fields: dst %h op %h tip %h want ff 01 66", cap[8], cap[29], cap[49]);
    end
    tests++; if (residue() !== 32'hC704_DD7B) begin fails++; $display("FAIL req_residue: got %h want c704dd7b", residue()); end
    tests++; if (done_at != 0 || done_cnt != 1) begin
      fails++; $display("FAIL req_done: at %0d count %0d want 0 1", done_at, done_cnt);
    end
    tests++; if (trail_idle != 12) begin fails++; $display("FAIL req_ifg: idle %0d want 12", trail_idle); end
  endtask

  task automatic test_reply();
    int nb;
    arp_tx_type = 1'b1; des_mac = 48'h30_9C_23_12_34_56; des_ip = 32'hC0_A8_01_14;
    build_exp(1'b1, 48'h30_9C_23_12_34_56, 32'hC0_A8_01_14);
    arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
    capture();
    tests++; if (cap_to || cap_len != 72) begin fails++; $display("FAIL rep_len: got %0d (timeout %0d) want 72", cap_len, cap_to); end
    nb = bad_bytes();
    tests++; if (nb != 0) begin fails++; $display("FAIL rep_bytes: %0d bytes differ, want 0", nb); end
    tests++; if (cap[8] !== 8'h30 || cap[13] !== 8'h56 || cap[29] !== 8'h02 || cap[40] !== 8'h30 || cap[45] !== 8'h56 || cap[49] !== 8'h14) begin
      fails++; $display("FAIL rep_fields: dst %h..%h op %h tmac %h..%h tip %h want 30..56 02 30..56 14",
                        cap[8], cap[13], cap[29], cap[40], cap[45], cap[49]);
    end
    tests++; if (residue() !== 32'hC704_DD7B) begin fails++; $display("FAIL rep_residue: got %h want c704dd7b", residue()); end
    tests++; if (done_at != 0 || done_cnt != 1) begin
      fails++; $display("FAIL rep_done: at %0d count %0d want 0 1", done_at, done_cnt);
    end
  endtask

  task automatic test_ignore_busy();
    int nb, hi;
    arp_tx_type = 1'b1; des_mac = 48'h30_9C_23_12_34_56; des_ip = 32'hC0_A8_01_14;
    build_exp(1'b1, 48'h30_9C_23_12_34_56, 32'hC0_A8_01_14);
    arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
    inj_at = 30; rel_at = 31; inj_ip = 32'hC0_A8_01_C8;
    capture();
    inj_at = -1; rel_at = -1;
    tests++; if (cap_to || cap_len != 72) begin fails++; $display("FAIL ign_len: got %0d want 72", cap_len); end
    nb = bad_bytes();
    tests++; if (nb != 0) begin fails++; $display("FAIL ign_bytes: %0d bytes differ, want 0", nb); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL ign_done: count %0d want 1", done_cnt); end
    hi = 0;
    for (int k = 0; k < 120; k++) begin
      if (gmii_tx_en !== 1'b0) hi++;
      @(negedge clk);
    end
    tests++; if (hi != 0) begin fails++; $display("FAIL ign_no_frame: %0d active cycles want 0", hi); end
  endtask

  task automatic test_back_to_back();
    int nb1, nb2, t1_idle, t1_busy, hi;
    arp_tx_type = 1'b0; des_mac = '0; des_ip = '0;
    build_exp(1'b0, 48'h0, 32'h0);
    arp_tx_en = 1'b1;
    capture();
    nb1 = bad_bytes();
    t1_idle = trail_idle;
    t1_busy = trail_busy_low;
    tests++; if (cap_to || cap_len != 72 || nb1 != 0) begin
      fails++; $display("FAIL b2b_frame1: len %0d bad %0d want 72 0", cap_len, nb1);
    end
    rel_at = 1;
    capture();
    rel_at = -1;
    arp_tx_en = 1'b0;
    nb2 = bad_bytes();
    tests++; if (cap_to || cap_len != 72 || nb2 != 0) begin
      fails++; $display("FAIL b2b_frame2: len %0d bad %0d want 72 0", cap_len, nb2);
    end
    tests++; if (t1_idle + wait_n != 13) begin fails++; $display("FAIL b2b_gap: got %0d want 13", t1_idle + wait_n); end
    tests++; if (t1_busy + wait_busy_low != 1) begin
      fails++; $display("FAIL b2b_busy_low: got %0d want 1", t1_busy + wait_busy_low);
    end
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (gmii_tx_en !== 1'b0) hi++;
      @(negedge clk);
    end
    tests++; if (hi != 0) begin fails++; $display("FAIL b2b_stop: %0d active cycles want 0", hi); end
  endtask

  task automatic test_reset_abort();
    int w, hi, nb;
    arp_tx_type = 1'b1; des_mac = 48'h30_9C_23_12_34_56; des_ip = 32'hC0_A8_01_14;
    arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
    w = 0;
    while (gmii_tx_en !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    tests++; if (gmii_tx_en !== 1'b1) begin fails++; $display("FAIL abort_start: tx_en %b want 1", gmii_tx_en); end
    repeat (40) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL abort_now: tx_en %b txd %h busy %b want 0 00 0", gmii_tx_en, gmii_txd, tx_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) hi++;
      @(negedge clk);
    end
    tests++; if (hi != 0) begin fails++; $display("FAIL abort_quiet: %0d active cycles want 0", hi); end
    arp_tx_type = 1'b0; des_mac = '0; des_ip = '0;
    build_exp(1'b0, 48'h0, 32'h0);
    arp_tx_en = 1'b1;
    @(negedge clk);
    arp_tx_en = 1'b0;
    capture();
    nb = bad_bytes();
    tests++; if (cap_to || cap_len != 72 || nb != 0) begin
      fails++; $display("FAIL abort_next: len %0d bad %0d want 72 0", cap_len, nb);
    end
    tests++; if (residue() !== 32'hC704_DD7B) begin fails++; $display("FAIL abort_residue: got %h want c704dd7b", residue()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_request();
    test_reply();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
